alarm_qsys_btn_debounce: RTL and testbench
==========================================

// Module: alarm_qsys_btn_debounce
// PURPOSE
//  Upstream conditioning stage for the button PIO. Takes raw KEY pins, synchronises them,
//  debounces each one and adds hold-to-repeat. btn_level drives the PIO in_port directly.
//  The PIO's level-sensitive irq therefore only ever sees clean press levels.
//  btn_press, btn_release and btn_repeat serve hardware consumers (time-set increment logic).
// PARAMETERS
//  BTN_COUNT      4      number of buttons
//  ACTIVE_LOW     1      1: raw pin 0 = pressed; 0: raw pin 1 = pressed
//  TICK_DIV       50000  clk cycles per sampling tick (1 ms @ 50 MHz); 1 = tick every cycle
//  DEBOUNCE_TICKS 20     consecutive disagreeing ticks needed to flip a level (>=1)
//  HOLD_TICKS     500    ticks a level must stay pressed before the first repeat
//  REPEAT_TICKS   100    ticks between later repeats; 0 disables repeat
// PORTS
//  clk          in   1          system clock
//  reset        in   1          asynchronous reset, active-high
//  btn_raw      in   BTN_COUNT  raw asynchronous button pins
//  btn_level    out  BTN_COUNT  debounced state, 1 = pressed (to PIO in_port)
//  btn_press    out  BTN_COUNT  1-cycle pulse on debounced 0->1
//  btn_release  out  BTN_COUNT  1-cycle pulse on debounced 1->0
//  btn_repeat   out  BTN_COUNT  1-cycle pulse per auto-repeat while held
// BEHAVIOUR
//  Decided: one clock, clk; reset is asynchronous and active-high, port named reset.
//  - Reset: every output is 0.
//    Sync flops take the released raw value, so releasing reset cannot fake an edge.
//    Prescaler and all counters are 0.
//  - Synchroniser: 2 flops per bit. Output s is polarity-corrected, 1 = pressed.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle count==TICK_DIV-1.
//    One prescaler is shared by all channels.
//  - Debounce (per channel, counter db_cnt):
//    - On any clk where s==btn_level, db_cnt clears to 0. A glitch between ticks therefore
//      restarts the count.
//    - On a tick with s!=btn_level: if db_cnt==DEBOUNCE_TICKS-1, btn_level flips and db_cnt
//      clears on that edge; otherwise db_cnt increments.
//  - Pulses: btn_press/btn_release are registered and assert on the same edge that flips
//    btn_level, high for exactly one cycle.
//  - Latency press->level: 2 sync cycles + DEBOUNCE_TICKS ticks, to within one TICK_DIV.
//  - Repeat (per channel, counter hold_cnt):
//    - hold_cnt is 0 while btn_level==0.
//    - While btn_level==1, hold_cnt increments on tick.
//    - Reaching HOLD_TICKS: btn_repeat pulses for one cycle and hold_cnt reloads to
//      HOLD_TICKS-REPEAT_TICKS.
//    - hold_cnt saturates and never wraps.
//    - No repeat on the press edge itself. None at all when REPEAT_TICKS==0.
//  - Simultaneous events: channels are fully independent; any mix of pulses may occur in one cycle.
//  - A release flip clears hold_cnt on the same edge. A repeat due on that edge is suppressed.
//  - Reset mid-operation:
//    - Outputs drop to 0 immediately (asynchronously).
//    - A button still held after reset deasserts re-debounces as a fresh press and yields one
//      btn_press.
//  - Widths: counters sized with $clog2(param+1). Every compare uses full-width unsigned values.
// STRUCTURE
//  - Shared package/header alarm_qsys_btn_pkg: default tick/debounce/hold constants and a
//    width helper function.
//  - Sub-module alarm_qsys_btn_chan: sync, db_cnt, hold_cnt and pulses for one button.
//    Instantiated BTN_COUNT times via generate.
//  - The prescaler stays in the top level.
// TESTING (bench params: TICK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4)
//  1. Reset: btn_raw=4'hF, pulse reset mid-cycle -> all outputs 0 at once; no pulse in the
//     next 200 cycles.
//  2. Clean press: btn_raw[0]=0 held -> btn_level[0]=1 and one btn_press[0] within 2+12+4 cycles.
//     Then raw[0]=1 -> one btn_release[0] within the same bound.
//  3. Bounce: toggle raw[1] every 3 cycles for 60 cycles, then hold low -> btn_level[1] stays 0
//     during bounce; exactly one press after 3 stable ticks.
//  4. Hold: raw[2] low for 40 ticks after debounce -> repeats at hold ticks 10, 14, 18 ... 38,
//     i.e. 8 pulses; none after release.
//  5. Simultaneous: raw[0] and raw[3] fall on the same cycle -> both btn_press pulses on the
//     same cycle; no cross-talk to channels 1 and 2.
//  6. Reset mid-hold: reset while btn_level[2]=1 and raw held -> outputs 0 immediately; after
//     reset deasserts, one fresh btn_press[2] after debounce.

Source files
------------

// File: rtl/alarm_qsys_btn_pkg.sv
// Shared constants and helpers for the button conditioning stage.
package alarm_qsys_btn_pkg;

  localparam int unsigned DEF_BTN_COUNT      = 4;
  localparam int unsigned DEF_TICK_DIV       = 50000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 20;
  localparam int unsigned DEF_HOLD_TICKS     = 500;
  localparam int unsigned DEF_REPEAT_TICKS   = 100;

  // Per-channel event pulses, each high for one clk cycle.
  typedef struct packed {
    logic press;
    logic rel;
    logic rpt;
  } btn_evt_t;

  // Bits needed to hold values 0..max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alarm_qsys_btn_debounce_if.sv
// Button bundle: raw pins in, debounced level and event pulses out.
interface alarm_qsys_btn_debounce_if
  import alarm_qsys_btn_pkg::*;
#(
  parameter int unsigned BTN_COUNT = DEF_BTN_COUNT
);

  logic [BTN_COUNT-1:0] btn_raw;
  logic [BTN_COUNT-1:0] btn_level;
  logic [BTN_COUNT-1:0] btn_press;
  logic [BTN_COUNT-1:0] btn_release;
  logic [BTN_COUNT-1:0] btn_repeat;

  // Consumer / pin-driver side.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Conditioning block side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/alarm_qsys_btn_chan.sv
// One button channel: synchroniser, debounce counter, hold/repeat counter, pulses.
module alarm_qsys_btn_chan
  import alarm_qsys_btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  logic     raw,
  output logic     level,
  output btn_evt_t evt
);

  localparam logic IDLE_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam int unsigned   DW      = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

  localparam int unsigned   HW          = cnt_width(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_RELOAD = (REPEAT_TICKS >= HOLD_TICKS) ? '0
                                          : HW'(HOLD_TICKS - REPEAT_TICKS);
  localparam bit            RPT_EN      = (REPEAT_TICKS != 0);

  logic          sync0;
  logic          sync1;
  logic          s;
  logic          flip;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;
  logic          press_q;
  logic          rel_q;
  logic          rpt_q;

  // Two-flop synchroniser; resets to the released pin value so reset exit is edge-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= IDLE_RAW;
      sync1 <= IDLE_RAW;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // Polarity correction and the "level flips on this edge" decision.
  always_comb begin
    s        = ACTIVE_LOW ? ~sync1 : sync1;
    flip     = tick && (s != level) && (db_cnt == DB_LAST);
    hold_inc = hold_cnt + 1'b1;
  end

  // Debounce: any agreeing cycle restarts the count; DEBOUNCE_TICKS disagreeing ticks flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 1'b0;
      db_cnt  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      if (s == level) begin
        db_cnt <= '0;
      end else if (flip) begin
        level   <= ~level;
        db_cnt  <= '0;
        press_q <= ~level;
        rel_q   <= level;
      end else if (tick) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hold-to-repeat; a release flip clears the count and suppresses a coincident repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      rpt_q    <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (!level || flip) begin
        hold_cnt <= '0;
      end else if (tick) begin
        if (RPT_EN && (hold_inc == HOLD_MAX)) begin
          rpt_q    <= 1'b1;
          hold_cnt <= HOLD_RELOAD;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_inc;
        end
      end
    end
  end

  // Pack the registered pulses for the top level.
  always_comb begin
    evt       = '0;
    evt.press = press_q;
    evt.rel   = rel_q;
    evt.rpt   = rpt_q;
  end

endmodule

// File: rtl/alarm_qsys_btn_debounce.sv
// Button conditioning stage: shared sampling prescaler plus one channel per button.
module alarm_qsys_btn_debounce
  import alarm_qsys_btn_pkg::*;
#(
  parameter int unsigned BTN_COUNT      = DEF_BTN_COUNT,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input logic                       clk,
  input logic                       reset,
  alarm_qsys_btn_debounce_if.slave  bus
);

  localparam int unsigned   PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]        presc;
  logic                 tick;
  logic [BTN_COUNT-1:0] level_v;
  btn_evt_t             evt [BTN_COUNT];
  logic [BTN_COUNT-1:0] press_v;
  logic [BTN_COUNT-1:0] rel_v;
  logic [BTN_COUNT-1:0] rpt_v;

  // Sampling prescaler, 0..TICK_DIV-1, shared by every channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Tick on the last prescaler count.
  always_comb begin
    tick = (presc == PRESC_LAST);
  end

  for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
    alarm_qsys_btn_chan #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (bus.btn_raw[g]),
      .level (level_v[g]),
      .evt   (evt[g])
    );
  end

  // Unpack per-channel events into the bus vectors.
  always_comb begin
    press_v = '0;
    rel_v   = '0;
    rpt_v   = '0;
    for (int unsigned i = 0; i < BTN_COUNT; i++) begin
      press_v[i] = evt[i].press;
      rel_v[i]   = evt[i].rel;
      rpt_v[i]   = evt[i].rpt;
    end
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;
  assign bus.btn_repeat  = rpt_v;

endmodule

// File: tb/tb_alarm_qsys_btn_debounce.sv
// Self-checking bench for alarm_qsys_btn_debounce: directed scenarios plus random pin activity
// compared cycle by cycle against a tick-arithmetic reference model.
module tb_alarm_qsys_btn_debounce;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 10;
  localparam int RT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_qsys_btn_debounce_if #(.BTN_COUNT(N)) bus ();

  alarm_qsys_btn_debounce #(
    .BTN_COUNT      (N),
    .ACTIVE_LOW     (1'b1),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DB),
    .HOLD_TICKS     (HT),
    .REPEAT_TICKS   (RT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edge index since reset, debounced levels, last edge where the
  // synchronised pin agreed with the level, and the edge of the most recent press.
  int           mk;
  logic [N-1:0] m_lvl;
  int           last_agree [N];
  int           press_at [N];
  logic [N-1:0] rawq [$];
  logic [N-1:0] e_press, e_rel, e_rep;

  int cnt_press [N];
  int cnt_rel [N];
  int cnt_rep [N];
  int lvl_high [N];
  int press_cyc [N];
  int gcyc = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of tick edges among edges 0..x (tick edges are those with index % TD == TD-1).
  function automatic int ticks_upto(input int x);
    return (x + 1) / TD;
  endfunction

  task automatic model_reset();
    mk     = 0;
    m_lvl  = '0;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int i = 0; i < N; i++) begin
      last_agree[i] = -1;
      press_at[i]   = 0;
    end
    rawq.delete();
    rawq.push_back('1);
    rawq.push_back('1);
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    bit tk;
    bit fl;
    int n;
    s = ~rawq.pop_front();
    rawq.push_back(raw);
    tk = (mk % TD) == TD - 1;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int i = 0; i < N; i++) begin
      fl = 1'b0;
      if (s[i] == m_lvl[i]) last_agree[i] = mk;
      else if (tk && (ticks_upto(mk) - ticks_upto(last_agree[i]) == DB)) fl = 1'b1;
      if (m_lvl[i] && !fl && tk) begin
        n = ticks_upto(mk) - ticks_upto(press_at[i]);
        if (n >= HT && ((n - HT) % RT) == 0) e_rep[i] = 1'b1;
      end
      if (fl) begin
        last_agree[i] = mk;
        if (m_lvl[i]) e_rel[i] = 1'b1;
        else begin
          e_press[i]  = 1'b1;
          press_at[i] = mk;
        end
        m_lvl[i] = ~m_lvl[i];
      end
    end
    mk++;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      cnt_press[i] = 0;
      cnt_rel[i]   = 0;
      cnt_rep[i]   = 0;
      lvl_high[i]  = 0;
      press_cyc[i] = -1;
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge(bus.btn_raw);
    @(negedge clk);
    gcyc++;
    check("level",   bus.btn_level,   m_lvl);
    check("press",   bus.btn_press,   e_press);
    check("release", bus.btn_release, e_rel);
    check("repeat",  bus.btn_repeat,  e_rep);
    for (int i = 0; i < N; i++) begin
      cnt_press[i] += int'(bus.btn_press[i]);
      cnt_rel[i]   += int'(bus.btn_release[i]);
      cnt_rep[i]   += int'(bus.btn_repeat[i]);
      lvl_high[i]  += int'(bus.btn_level[i]);
      if (bus.btn_press[i]) press_cyc[i] = gcyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_level",   bus.btn_level,   '0);
    check("rst_press",   bus.btn_press,   '0);
    check("rst_release", bus.btn_release, '0);
    check("rst_repeat",  bus.btn_repeat,  '0);
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    clear_counts();
  endtask

  task automatic wait_press(input int ch, input int budget);
    int b = 0;
    while (cnt_press[ch] == 0 && b < budget) begin
      cyc();
      b++;
    end
  endtask

  task automatic wait_release(input int ch, input int budget);
    int b = 0;
    while (cnt_rel[ch] == 0 && b < budget) begin
      cyc();
      b++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_raw = '1;
    clear_counts();
    @(negedge clk);
    check("init_level", bus.btn_level, '0);
    check("init_press", bus.btn_press, '0);
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();

    // 1. Reset with all pins released, then a quiet window.
    run(5);
    do_reset();
    run(200);
    check_int("p1_no_pulses",
              cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3] +
              cnt_rel[0] + cnt_rel[1] + cnt_rel[2] + cnt_rel[3] +
              cnt_rep[0] + cnt_rep[1] + cnt_rep[2] + cnt_rep[3], 0);

    // 2. Clean press and release on channel 0.
    clear_counts();
    bus.btn_raw[0] = 1'b0;
    run(18);
    check_int("p2_level_up", int'(bus.btn_level[0]), 1);
    check_int("p2_press_cnt", cnt_press[0], 1);
    bus.btn_raw[0] = 1'b1;
    run(18);
    check_int("p2_level_down", int'(bus.btn_level[0]), 0);
    check_int("p2_release_cnt", cnt_rel[0], 1);

    // 3. Bouncing pin on channel 1, then held.
    clear_counts();
    for (int t = 0; t < 20; t++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      run(3);
    end
    check_int("p3_bounce_level", lvl_high[1], 0);
    bus.btn_raw[1] = 1'b0;
    run(24);
    check_int("p3_press_cnt", cnt_press[1], 1);
    bus.btn_raw = '1;
    run(20);

    // 4. Hold channel 2 for 40 ticks after debounce.
    clear_counts();
    bus.btn_raw[2] = 1'b0;
    wait_press(2, 18);
    check_int("p4_press_seen", cnt_press[2], 1);
    cnt_rep[2] = 0;
    run(160);
    check_int("p4_repeat_cnt", cnt_rep[2], 8);
    bus.btn_raw[2] = 1'b1;
    wait_release(2, 18);
    check_int("p4_release_seen", cnt_rel[2], 1);
    cnt_rep[2] = 0;
    run(20);
    check_int("p4_no_repeat_after", cnt_rep[2], 0);

    // 5. Channels 0 and 3 pressed together.
    clear_counts();
    bus.btn_raw[0] = 1'b0;
    bus.btn_raw[3] = 1'b0;
    wait_press(3, 18);
    check_int("p5_press0", cnt_press[0], 1);
    check_int("p5_press3", cnt_press[3], 1);
    check_int("p5_same_cycle", press_cyc[0], press_cyc[3]);
    check_int("p5_no_xtalk", cnt_press[1] + cnt_press[2] + lvl_high[1] + lvl_high[2], 0);
    bus.btn_raw = '1;
    run(20);

    // 6. Reset while channel 2 is held.
    clear_counts();
    bus.btn_raw[2] = 1'b0;
    wait_press(2, 18);
    run(30);
    check_int("p6_held", int'(bus.btn_level[2]), 1);
    do_reset();
    run(18);
    check_int("p6_fresh_press", cnt_press[2], 1);
    check_int("p6_level_again", int'(bus.btn_level[2]), 1);
    bus.btn_raw = '1;
    run(20);

    // 7. Random pin activity at slow, medium and fast change rates, one reset midway.
    for (int c = 0; c < 3000; c++) begin
      int unsigned rate;
      int unsigned b;
      rate = (c < 1000) ? 63 : ((c < 2000) ? 15 : 3);
      if ($urandom_range(0, rate) == 0) begin
        b = $urandom_range(0, N - 1);
        bus.btn_raw[b] = ~bus.btn_raw[b];
      end
      if (c == 1500) do_reset();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
